// File: rtl/joybus_pkg.sv
// joybus_pkg: JOYBUS command/status constants and the command arbiter state encoding.
package joybus_pkg;

  localparam logic [7:0] JB_CMD_STATUS = 8'h00;
  localparam logic [7:0] JB_CMD_POLL   = 8'h01;
  localparam logic [7:0] JB_CMD_RESET  = 8'hFF;

  localparam logic [7:0] JB_STATUS_OK  = 8'h05;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_TX = 3'd2,
    WAIT_RX = 3'd3,
    GAP     = 3'd4
  } arb_state_e;

endpackage

// File: rtl/jb_rr_pick.sv
// jb_rr_pick: combinational round-robin picker; the first requester after ptr (with wrap) wins.
module jb_rr_pick
  import joybus_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  int dist_s;
  int best_s;

  // Pick the requester with the smallest rotational distance from ptr+1.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    dist_s = 0;
    best_s = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      dist_s = (j + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
      if (req[j] && (dist_s < best_s)) begin
        best_s = dist_s;
        idx    = IW'(j);
      end else begin
        best_s = best_s;
      end
    end
    if (|req) begin
      gnt[idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/joybus_cmd_arbiter.sv
// joybus_cmd_arbiter: round-robin sharing of one JOYBUS tx/rx engine among NUM_REQ requesters.
// Optional macro JB_ARB_STATS_EN adds saturating xact_cnt/tout_cnt outputs.
module joybus_cmd_arbiter
  import joybus_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int GAP_CYCLES     = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_vld,
  output logic                   rsp_err,
  output logic [7:0]             rsp_status,
  output logic [31:0]            rsp_data,
  output logic                   busy,
  output logic                   cmd_rdy,
  output logic [7:0]             cmd_data,
  input  logic                   tx_done,
  input  logic                   rx_done,
  input  logic [7:0]             rx_status,
  input  logic [31:0]            rx_data,
  output logic                   eng_abort
`ifdef JB_ARB_STATS_EN
  ,
  output logic [15:0]            xact_cnt,
  output logic [15:0]            tout_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  arb_state_e         state_r, state_s;
  logic [IW-1:0]      ptr_r, ptr_s, owner_r, owner_s, pick_idx_s;
  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [7:0]         cmd_sel_s;
  logic [TW-1:0]      tmo_cnt_r, tmo_cnt_s;
  logic [GW-1:0]      gap_cnt_r, gap_cnt_s;
  logic               fin_ok_s, fin_err_s;

  logic [NUM_REQ-1:0] gnt_r, gnt_s, rsp_vld_r, rsp_vld_s;
  logic               rsp_err_r, rsp_err_s, busy_r, busy_s;
  logic               cmd_rdy_r, cmd_rdy_s, eng_abort_r, eng_abort_s;
  logic [7:0]         rsp_status_r, rsp_status_s, cmd_data_r, cmd_data_s;
  logic [31:0]        rsp_data_r, rsp_data_s;

  jb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Command byte of the requester the picker selected.
  always_comb begin
    cmd_sel_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == IW'(i)) begin
        cmd_sel_s = req_cmd[8*i +: 8];
      end else begin
        cmd_sel_s = cmd_sel_s;
      end
    end
  end

  // Next-state logic; outputs are computed one cycle ahead and registered below.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    owner_s      = owner_r;
    tmo_cnt_s    = tmo_cnt_r;
    gap_cnt_s    = gap_cnt_r;
    gnt_s        = '0;
    cmd_rdy_s    = 1'b0;
    cmd_data_s   = 8'h00;
    rsp_vld_s    = '0;
    rsp_err_s    = 1'b0;
    rsp_status_s = rsp_status_r;
    rsp_data_s   = rsp_data_r;
    eng_abort_s  = 1'b0;
    fin_ok_s     = 1'b0;
    fin_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          owner_s    = pick_idx_s;
          ptr_s      = pick_idx_s;
          tmo_cnt_s  = '0;
          gnt_s      = pick_gnt_s;
          cmd_rdy_s  = 1'b1;
          cmd_data_s = cmd_sel_s;
          state_s    = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        tmo_cnt_s = tmo_cnt_r + TW'(1);
        state_s   = WAIT_TX;
      end
      WAIT_TX, WAIT_RX: begin
        // A response arriving on the timeout cycle still counts as a good one.
        if ((state_r == WAIT_RX) && rx_done) begin
          fin_ok_s = 1'b1;
        end else if (tmo_cnt_r >= TMO_LAST) begin
          fin_err_s = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
          if ((state_r == WAIT_TX) && tx_done) begin
            state_s = WAIT_RX;
          end else begin
            state_s = state_r;
          end
        end
      end
      GAP: begin
        if (gap_cnt_r >= GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (fin_ok_s || fin_err_s) begin
      rsp_vld_s    = NUM_REQ'(1) << owner_r;
      rsp_err_s    = fin_err_s;
      eng_abort_s  = fin_err_s;
      rsp_status_s = fin_ok_s ? rx_status : 8'h00;
      rsp_data_s   = fin_ok_s ? rx_data : 32'h0000_0000;
      gap_cnt_s    = '0;
      state_s      = (GAP_CYCLES == 0) ? IDLE : GAP;
    end else begin
      rsp_vld_s = '0;
    end
    busy_s = (state_s != IDLE);
  end

  // FSM state, round-robin pointer and cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= IW'(NUM_REQ - 1);
      owner_r   <= '0;
      tmo_cnt_r <= '0;
      gap_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      tmo_cnt_r <= tmo_cnt_s;
      gap_cnt_r <= gap_cnt_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r        <= '0;
      rsp_vld_r    <= '0;
      rsp_err_r    <= 1'b0;
      rsp_status_r <= 8'h00;
      rsp_data_r   <= 32'h0000_0000;
      busy_r       <= 1'b0;
      cmd_rdy_r    <= 1'b0;
      cmd_data_r   <= 8'h00;
      eng_abort_r  <= 1'b0;
    end else begin
      gnt_r        <= gnt_s;
      rsp_vld_r    <= rsp_vld_s;
      rsp_err_r    <= rsp_err_s;
      rsp_status_r <= rsp_status_s;
      rsp_data_r   <= rsp_data_s;
      busy_r       <= busy_s;
      cmd_rdy_r    <= cmd_rdy_s;
      cmd_data_r   <= cmd_data_s;
      eng_abort_r  <= eng_abort_s;
    end
  end

  assign gnt        = gnt_r;
  assign rsp_vld    = rsp_vld_r;
  assign rsp_err    = rsp_err_r;
  assign rsp_status = rsp_status_r;
  assign rsp_data   = rsp_data_r;
  assign busy       = busy_r;
  assign cmd_rdy    = cmd_rdy_r;
  assign cmd_data   = cmd_data_r;
  assign eng_abort  = eng_abort_r;

`ifdef JB_ARB_STATS_EN
  logic [15:0] xact_cnt_r, tout_cnt_r;

  // Saturating good-transaction and timeout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xact_cnt_r <= 16'h0000;
      tout_cnt_r <= 16'h0000;
    end else begin
      if (fin_ok_s && (xact_cnt_r != 16'hFFFF)) begin
        xact_cnt_r <= xact_cnt_r + 16'd1;
      end
      if (fin_err_s && (tout_cnt_r != 16'hFFFF)) begin
        tout_cnt_r <= tout_cnt_r + 16'd1;
      end
    end
  end

  assign xact_cnt = xact_cnt_r;
  assign tout_cnt = tout_cnt_r;
`endif

endmodule

// File: tb/tb_joybus_cmd_arbiter.sv
// tb_joybus_cmd_arbiter: table vectors, directed corner sequences and random traffic
// checked against a transaction-level reference model.
module tb_joybus_cmd_arbiter;
  import joybus_pkg::*;

  localparam int N  = 3;
  localparam int T  = 40;
  localparam int G  = 4;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7:0]     cmd_arr [N];
  logic [8*N-1:0] req_cmd;
  logic           tx_done = 1'b0;
  logic           rx_done = 1'b0;
  logic [7:0]     rx_status = 8'h00;
  logic [31:0]    rx_data = 32'h0;
  logic [N-1:0]   gnt, rsp_vld;
  logic           rsp_err, busy, cmd_rdy, eng_abort;
  logic [7:0]     rsp_status, cmd_data;
  logic [31:0]    rsp_data;
`ifdef JB_ARB_STATS_EN
  logic [15:0]    xact_cnt, tout_cnt;
`endif

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_cmd[8*i +: 8] = cmd_arr[i];
  end

  joybus_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .gnt(gnt),
    .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .busy(busy), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data), .tx_done(tx_done),
    .rx_done(rx_done), .rx_status(rx_status), .rx_data(rx_data), .eng_abort(eng_abort)
`ifdef JB_ARB_STATS_EN
    , .xact_cnt(xact_cnt), .tout_cnt(tout_cnt)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: transaction age since cmd_rdy, remaining gap cycles, last winner.
  bit          m_active, m_tx_seen;
  int          m_age, m_gap, m_last, m_owner, m_xact, m_tout;
  logic [7:0]  m_status;
  logic [31:0] m_data;
  logic [N-1:0] e_gnt, e_vld;
  logic        e_err, e_busy, e_rdy, e_abort;
  logic [7:0]  e_cmd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_tx_seen = 1'b0; m_age = 0; m_gap = 0; m_last = N - 1;
    m_owner = 0; m_status = 8'h00; m_data = 32'h0; m_xact = 0; m_tout = 0;
  endtask

  task automatic model_finish(input bit err);
    e_vld[IW'(m_owner)] = 1'b1;
    e_err = err; e_abort = err;
    m_status = err ? 8'h00 : rx_status;
    m_data   = err ? 32'h0 : rx_data;
    if (err) m_tout++; else m_xact++;
    m_active = 1'b0;
    m_gap = G;
  endtask

  // Predict outputs after the coming clock edge from the inputs about to be sampled.
  task automatic model_step();
    bit found;
    int j;
    e_gnt = '0; e_vld = '0; e_err = 1'b0; e_rdy = 1'b0; e_abort = 1'b0; e_cmd = 8'h00;
    if (m_active) begin
      if (m_age == 0) m_age = 1;
      else if (m_tx_seen && rx_done) model_finish(1'b0);
      else if (m_age >= T - 1) model_finish(1'b1);
      else begin
        if (tx_done) m_tx_seen = 1'b1;
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && req[IW'(j)]) begin found = 1'b1; m_owner = j; end
      end
      m_last = m_owner;
      e_gnt[IW'(m_owner)] = 1'b1;
      e_rdy = 1'b1;
      e_cmd = cmd_arr[IW'(m_owner)];
      m_active = 1'b1; m_tx_seen = 1'b0; m_age = 0;
    end
    e_busy = m_active || (m_gap > 0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("ctl", 64'({gnt, rsp_vld, rsp_err, busy, cmd_rdy, eng_abort}),
          64'({e_gnt, e_vld, e_err, e_busy, e_rdy, e_abort}));
    check("rsp", 64'({rsp_status, rsp_data}), 64'({m_status, m_data}));
    if (e_rdy) check("cmd", 64'(cmd_data), 64'(e_cmd));
`ifdef JB_ARB_STATS_EN
    check("stats", 64'({xact_cnt, tout_cnt}), 64'({16'(m_xact), 16'(m_tout)}));
`endif
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ctl", 64'({gnt, rsp_vld, rsp_err, busy, cmd_rdy, eng_abort, cmd_data}), 64'(0));
    check("rst_rsp", 64'({rsp_status, rsp_data}), 64'(0));
    model_reset();
    req = '0; tx_done = 1'b0; rx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req = '0; tx_done = 1'b1; rx_done = 1'b1;
    for (int c = 0; c < 60 && (m_active || m_gap > 0); c++) step();
    tx_done = 1'b0; rx_done = 1'b0;
    check("drain_idle", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [N-1:0] req; logic [23:0] cmds; logic tx; logic rx; logic [7:0] st; logic [31:0] dat;
    logic [N-1:0] gnt; logic rdy; logic [7:0] cmd; logic [N-1:0] vld; logic [31:0] rdat; logic busy;
  } vec_t;

  vec_t tbl [9];
  logic [N-1:0] gseq [4];
  int           gtim [4];
  logic [N-1:0] rr_exp [4];
  int ng, t_rdy;
  bit seen;

  initial begin
    for (int i = 0; i < N; i++) cmd_arr[i] = 8'h00;
    tbl[0] = '{3'b001, 24'h000001, 1'b0, 1'b0, 8'h00, 32'h0, 3'b001, 1'b1, 8'h01, 3'b000, 32'h0, 1'b1};
    tbl[1] = '{3'b000, 24'h000001, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000, 1'b0, 8'h00, 3'b000, 32'h0, 1'b1};
    tbl[2] = '{3'b000, 24'h000001, 1'b1, 1'b0, 8'h00, 32'h0, 3'b000, 1'b0, 8'h00, 3'b000, 32'h0, 1'b1};
    tbl[3] = '{3'b000, 24'h000001, 1'b0, 1'b1, 8'h05, 32'h8000_0000, 3'b000, 1'b0, 8'h00, 3'b001, 32'h8000_0000, 1'b1};
    tbl[4] = '{3'b000, 24'h000001, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000, 1'b0, 8'h00, 3'b000, 32'h8000_0000, 1'b1};
    tbl[5] = '{3'b010, 24'h00FF01, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000, 1'b0, 8'h00, 3'b000, 32'h8000_0000, 1'b1};
    tbl[6] = '{3'b010, 24'h00FF01, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000, 1'b0, 8'h00, 3'b000, 32'h8000_0000, 1'b1};
    tbl[7] = '{3'b010, 24'h00FF01, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000, 1'b0, 8'h00, 3'b000, 32'h8000_0000, 1'b0};
    tbl[8] = '{3'b010, 24'h00FF01, 1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b1, 8'hFF, 3'b000, 32'h8000_0000, 1'b1};
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    model_reset();
    repeat (2) @(negedge clk);
    check("por_ctl", 64'({gnt, rsp_vld, rsp_err, busy, cmd_rdy, eng_abort}), 64'(0));
    rst_n = 1'b1;

    // Basic transaction, gap and rotation through the vector table.
    for (int v = 0; v < 9; v++) begin
      req = tbl[v].req; tx_done = tbl[v].tx; rx_done = tbl[v].rx;
      rx_status = tbl[v].st; rx_data = tbl[v].dat;
      cmd_arr[0] = tbl[v].cmds[7:0]; cmd_arr[1] = tbl[v].cmds[15:8]; cmd_arr[2] = tbl[v].cmds[23:16];
      step();
      check("tbl_ctl", 64'({gnt, cmd_rdy, rsp_vld, busy}), 64'({tbl[v].gnt, tbl[v].rdy, tbl[v].vld, tbl[v].busy}));
      check("tbl_data", 64'(rsp_data), 64'(tbl[v].rdat));
      if (tbl[v].rdy) check("tbl_cmd", 64'(cmd_data), 64'(tbl[v].cmd));
    end

    // Reset while the requester-1 transaction sits in WAIT_RX.
    req = '0; tx_done = 1'b1; step(); step();
    tx_done = 1'b0; step();
    async_reset();
    req = 3'b110; step();
    check("post_rst_gnt", 64'(gnt), 64'(3'b010));
    drain();

    // All requesters held, instant engine: strict rotation with gap spacing.
    async_reset();
    req = 3'b111; tx_done = 1'b1; rx_done = 1'b1; ng = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      step();
      if (cmd_rdy) begin gseq[ng] = gnt; gtim[ng] = cyc; ng++; end
    end
    check("rr_count", 64'(ng), 64'(4));
    for (int k = 0; k < ng; k++) check("rr_order", 64'(gseq[k]), 64'(rr_exp[k]));
    for (int k = 1; k < ng; k++) check("rr_spacing", 64'(gtim[k] - gtim[k-1] >= G + 3), 64'(1));
    drain();

    // Timeout: tx completes, rx never arrives.
    req = 3'b001; step();
    check("tmo_issue", 64'(cmd_rdy), 64'(1));
    t_rdy = cyc;
    req = '0; tx_done = 1'b1; step(); step();
    tx_done = 1'b0; seen = 1'b0;
    for (int c = 0; c < 2*T && !seen; c++) begin
      step();
      if (eng_abort) begin
        seen = 1'b1;
        check("tmo_latency", 64'(cyc - t_rdy), 64'(T));
        check("tmo_rsp", 64'({rsp_vld, rsp_err, rsp_status, rsp_data}), 64'({3'b001, 1'b1, 8'h00, 32'h0}));
`ifdef JB_ARB_STATS_EN
        check("stats_fixed", 64'({xact_cnt, tout_cnt}), 64'({16'd4, 16'd1}));
`endif
      end
    end
    check("tmo_seen", 64'(seen), 64'(1));
    req = 3'b100; seen = 1'b0;
    for (int c = 0; c < G + 6 && !seen; c++) begin
      step();
      if (cmd_rdy) begin seen = 1'b1; check("tmo_next_gnt", 64'(gnt), 64'(3'b100)); end
    end
    check("tmo_next_seen", 64'(seen), 64'(1));
    drain();

    // rx_done on the very cycle the timeout would fire.
    req = 3'b001; cmd_arr[0] = JB_CMD_POLL; step();
    check("coinc_issue", 64'({cmd_rdy, cmd_data}), 64'({1'b1, JB_CMD_POLL}));
    req = '0; rx_status = JB_STATUS_OK; rx_data = 32'hCAFE_0001;
    for (int j = 1; j <= T; j++) begin
      tx_done = (j == 2); rx_done = (j == T);
      step();
    end
    check("coinc_rsp", 64'({rsp_vld, rsp_err, eng_abort}), 64'({3'b001, 1'b0, 1'b0}));
    check("coinc_data", 64'({rsp_status, rsp_data}), 64'({8'h05, 32'hCAFE_0001}));
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[IW'(i)]) req[IW'(i)] = 1'b0;
        else if (!req[IW'(i)] && $urandom_range(0, 7) == 0) begin
          req[IW'(i)] = 1'b1; cmd_arr[IW'(i)] = 8'($urandom);
        end else if (req[IW'(i)] && $urandom_range(0, 63) == 0) req[IW'(i)] = 1'b0;
      end
      tx_done = ($urandom_range(0, 5) == 0);
      rx_done = ($urandom_range(0, 15) == 0);
      rx_status = 8'($urandom);
      rx_data = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
